// File: rtl/arb_wrr_grant_ctrl.sv
// arb_wrr_grant_ctrl
//   Weighted round-robin grant controller. Each requester holds a credit
//   counter that is reloaded from its programmable weight at the start of
//   every round. One-hot grants go out in round-robin order to requesters that
//   are still requesting and still hold credit, over a valid/ready handshake.
//   When requests exist but none has credit left, the round is flagged as
//   complete and credits are reloaded without outside help.
//
//   Optional feature macro: ARB_WRR_ROUND_CNT_EN adds a completed-round
//   counter on round_cnt_o.
//
// Ports
//   clk              clock, rising edge
//   rst              synchronous active-high reset
//   req_i            [N]    request per requester
//   req_weight_i     [N*W]  packed weights, requester i at [i*W +: W]
//   grant_o          [N]    one-hot grant, zero when no grant is pending
//   grant_valid_o           grant pending
//   grant_ready_i           consumer accepts the current grant
//   weight_remain_o  [N]    bit i set while credit[i] is nonzero
//   round_comp_o            one-cycle round-completion pulse
//   round_cnt_o      [CW]   completed-round count (ARB_WRR_ROUND_CNT_EN only)

// Per-requester credit counter. Loads the weight at round start and counts
// down by one for every accepted grant; never goes below zero.
module arb_wrr_credit_lane #(
  parameter int P_WEIGHT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [P_WEIGHT_W-1:0] weight_i,
  input  logic                  dec_i,
  output logic                  nz_o
);
  logic [P_WEIGHT_W-1:0] credit_q, credit_d;

  always_comb begin
    credit_d = credit_q;
    if (load_i)
      credit_d = weight_i;
    else if (dec_i && (credit_q != '0))
      credit_d = credit_q - P_WEIGHT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) credit_q <= '0;
    else     credit_q <= credit_d;
  end

  assign nz_o = (credit_q != '0);
endmodule

module arb_wrr_grant_ctrl #(
  parameter int P_REQUESTER_NUM = 4,
  parameter int P_WEIGHT_W      = 3,
  parameter int P_ROUND_CNT_W   = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [P_REQUESTER_NUM-1:0]            req_i,
  input  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] req_weight_i,
  output logic [P_REQUESTER_NUM-1:0]            grant_o,
  output logic                                  grant_valid_o,
  input  logic                                  grant_ready_i,
  output logic [P_REQUESTER_NUM-1:0]            weight_remain_o,
  output logic                                  round_comp_o
`ifdef ARB_WRR_ROUND_CNT_EN
  ,
  output logic [P_ROUND_CNT_W-1:0]              round_cnt_o
`endif
);
  localparam int N     = P_REQUESTER_NUM;
  localparam int PTR_W = $clog2(N);

  typedef enum logic [1:0] {RELOAD, ARB, GRANT} state_e;

  typedef struct packed {
    logic [N-1:0]     onehot;
    logic [PTR_W-1:0] idx;
  } grant_t;

  state_e           state_q, state_d;
  grant_t           grant_q, grant_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             comp_q, comp_d;

  logic             load;
  logic             dec;
  logic [N-1:0]     dec_vec;
  logic [N-1:0]     elig;
  logic             sel_found;
  logic [PTR_W-1:0] sel_idx;

  // Credit counters, one lane per requester; the packed weight bus and the
  // decrement vector split across the instance array.
  assign dec_vec = {N{dec}} & grant_q.onehot;

  arb_wrr_credit_lane #(.P_WEIGHT_W(P_WEIGHT_W)) u_lane [N-1:0] (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .weight_i (req_weight_i),
    .dec_i    (dec_vec),
    .nz_o     (weight_remain_o)
  );

  // Rotating priority scan starting at ptr; first eligible index wins.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    elig      = req_i & weight_remain_o;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!sel_found && elig[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    comp_d  = 1'b0;
    load    = 1'b0;
    dec     = 1'b0;
    case (state_q)
      RELOAD: begin
        load    = 1'b1;
        state_d = ARB;
      end
      ARB: begin
        if (sel_found) begin
          grant_d.onehot = {{(N-1){1'b0}}, 1'b1} << sel_idx;
          grant_d.idx    = sel_idx;
          state_d        = GRANT;
        end else if (|req_i) begin
          // Requests pending but no credit anywhere: the round is over.
          comp_d  = 1'b1;
          state_d = RELOAD;
        end
      end
      GRANT: begin
        // Grant is held even if the request drops; only ready releases it.
        if (grant_ready_i) begin
          dec     = 1'b1;
          ptr_d   = (grant_q.idx == PTR_W'(N-1)) ? '0 : grant_q.idx + PTR_W'(1);
          grant_d = '0;
          state_d = ARB;
        end
      end
      default: state_d = RELOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RELOAD;
      grant_q <= '0;
      ptr_q   <= '0;
      comp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      comp_q  <= comp_d;
    end
  end

  assign grant_o       = grant_q.onehot;
  assign grant_valid_o = (state_q == GRANT);
  assign round_comp_o  = comp_q;

`ifdef ARB_WRR_ROUND_CNT_EN
  logic [P_ROUND_CNT_W-1:0] rcnt_q, rcnt_d;

  // Advances on the same edge that raises round_comp_o.
  assign rcnt_d = comp_d ? rcnt_q + P_ROUND_CNT_W'(1) : rcnt_q;

  always_ff @(posedge clk) begin
    if (rst) rcnt_q <= '0;
    else     rcnt_q <= rcnt_d;
  end

  assign round_cnt_o = rcnt_q;
`endif
endmodule

// File: tb/tb_arb_wrr_grant_ctrl.sv
module tb_arb_wrr_grant_ctrl;
  localparam int N = 4;
  localparam int W = 3;
`ifdef ARB_WRR_ROUND_CNT_EN
  localparam int CW = 2;
`endif

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] req_weight_i;
  logic [N-1:0]   grant_o;
  logic           grant_valid_o;
  logic           grant_ready_i;
  logic [N-1:0]   weight_remain_o;
  logic           round_comp_o;
`ifdef ARB_WRR_ROUND_CNT_EN
  logic [CW-1:0]  round_cnt_o;
`endif

  arb_wrr_grant_ctrl #(
    .P_REQUESTER_NUM (N),
    .P_WEIGHT_W      (W)
`ifdef ARB_WRR_ROUND_CNT_EN
    ,.P_ROUND_CNT_W  (CW)
`endif
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_i           (req_i),
    .req_weight_i    (req_weight_i),
    .grant_o         (grant_o),
    .grant_valid_o   (grant_valid_o),
    .grant_ready_i   (grant_ready_i),
    .weight_remain_o (weight_remain_o),
    .round_comp_o    (round_comp_o)
`ifdef ARB_WRR_ROUND_CNT_EN
    ,.round_cnt_o    (round_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] sb[$];

  typedef struct {
    logic [N*W-1:0] w_init;
    logic [N*W-1:0] w_mid;   // applied after the first observed grant
    logic [N-1:0]   req;
    string          seq;     // expected grant indices, in order
    int             rounds;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pk(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  // Holds reset for 3 edges with the given stimulus; returns just after the
  // edge, so the next negedge is the first post-reset (RELOAD) cycle.
  task automatic start(input logic [N*W-1:0] w, input logic [N-1:0] r, input logic rdy);
    @(posedge clk); #1;
    rst = 1'b1; req_i = r; req_weight_i = w; grant_ready_i = rdy;
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    bit seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (grant_valid_o) begin seen = 1; break; end
    end
    chk({nm, " valid seen"}, 32'(seen), 1);
  endtask

  // Pops the scoreboard on every accepted grant until it is empty and the
  // expected number of round pulses has been seen.
  task automatic drain(input string nm, input logic [N*W-1:0] wmid, input int rounds);
    int pulses = 0;
    bit first  = 1;
    bit done   = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (round_comp_o) begin
        pulses++;
        chk({nm, " no credit at pulse"}, 32'(weight_remain_o & req_i), 0);
      end
      if (grant_valid_o && grant_ready_i) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s extra grant act=%0h exp=none", nm, grant_o);
        end else begin
          chk({nm, " grant"}, 32'(grant_o), 32'(sb.pop_front()));
        end
        if (first) begin req_weight_i = wmid; first = 0; end
      end
      if (sb.size() == 0 && pulses >= rounds) begin done = 1; break; end
    end
    chk({nm, " completed"}, 32'(done), 1);
    chk({nm, " rounds"}, 32'(pulses), 32'(rounds));
  endtask

  task automatic push_seq(input string s);
    for (int k = 0; k < s.len(); k++) begin
      logic [N-1:0] oh;
      oh = '0;
      oh[s[k] - "0"] = 1'b1;
      sb.push_back(oh);
    end
  endtask

  initial begin
    vecs[0] = '{pk(1,2,3,0), pk(1,2,3,0), 4'b1111, "012122012122", 2};
    vecs[1] = '{pk(2,2,2,2), pk(2,2,2,2), 4'b0101, "0202",         1};
    vecs[2] = '{pk(7,0,0,1), pk(7,0,0,1), 4'b1001, "03000000",     1};
    vecs[3] = '{pk(1,1,0,0), pk(3,1,0,0), 4'b0011, "010100",       2};
    vecs[4] = '{pk(1,1,1,1), pk(1,1,1,1), 4'b1010, "13",           1};

    // Reset with requests active, then first-grant latency.
    rst = 1'b1; req_i = 4'b1111; req_weight_i = pk(1,2,3,0); grant_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst grant", 32'(grant_o), 0);
    chk("rst valid", 32'(grant_valid_o), 0);
    chk("rst comp", 32'(round_comp_o), 0);
    chk("rst remain", 32'(weight_remain_o), 0);
`ifdef ARB_WRR_ROUND_CNT_EN
    chk("rst rcnt", 32'(round_cnt_o), 0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("rel c%0d valid", c), 32'(grant_valid_o), (c == 3) ? 1 : 0);
      chk($sformatf("rel c%0d comp", c), 32'(round_comp_o), 0);
    end
    chk("rel first grant", 32'(grant_o), 32'b0001);

    // Table-driven grant-order vectors.
    foreach (vecs[i]) begin
      start(vecs[i].w_init, vecs[i].req, 1'b1);
      push_seq(vecs[i].seq);
      drain($sformatf("vec%0d", i), vecs[i].w_mid, vecs[i].rounds);
    end

    // Backpressure: grant held while the granted request drops.
    start(pk(1,2,3,0), 4'b1111, 1'b0);
    wait_valid("bp");
    sb.push_back(4'b0001);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) req_i = 4'b1110;
      chk($sformatf("bp hold%0d grant", c), 32'(grant_o), 32'(sb[0]));
      chk($sformatf("bp hold%0d valid", c), 32'(grant_valid_o), 1);
      chk($sformatf("bp hold%0d remain", c), 32'(weight_remain_o), 32'b0111);
      @(negedge clk);
    end
    grant_ready_i = 1'b1;
    chk("bp accept grant", 32'(grant_o), 32'(sb.pop_front()));
    @(negedge clk);
    chk("bp after valid", 32'(grant_valid_o), 0);
    chk("bp after remain", 32'(weight_remain_o), 32'b0110);

    // Idle with partial credits, then resume from preserved credits and ptr.
    start(pk(2,2,0,0), 4'b0011, 1'b1);
    wait_valid("idle");
    chk("idle first grant", 32'(grant_o), 32'b0001);
    req_i = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("idle c%0d valid", c), 32'(grant_valid_o), 0);
      chk($sformatf("idle c%0d comp", c), 32'(round_comp_o), 0);
      chk($sformatf("idle c%0d remain", c), 32'(weight_remain_o), 32'b0011);
    end
    req_i = 4'b0011;
    push_seq("101");
    drain("idle resume", pk(2,2,0,0), 1);

    // All weights zero: RELOAD/ARB cycling, pulse every 2 cycles, no grants.
    start(pk(0,0,0,0), 4'b1111, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("zero c%0d valid", c), 32'(grant_valid_o), 0);
      chk($sformatf("zero c%0d comp", c), 32'(round_comp_o), (c >= 3 && (c % 2) == 1) ? 1 : 0);
    end

`ifdef ARB_WRR_ROUND_CNT_EN
    // Round counter wraps at 2^CW.
    begin
      int exp_cnt = 0;
      int n = 0;
      start(pk(1,0,0,0), 4'b0001, 1'b1);
      for (int c = 0; c < 100 && n < 5; c++) begin
        @(negedge clk);
        if (round_comp_o) begin
          exp_cnt = (exp_cnt + 1) % (1 << CW);
          chk($sformatf("rcnt round%0d", n), 32'(round_cnt_o), 32'(exp_cnt));
          n++;
        end
      end
      chk("rcnt rounds seen", 32'(n), 5);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
